// File: rtl/seg_capture_pkg.sv
// Shared constants for the seven-segment capture block: segment patterns
// (active-low, bit order gfedcba) and the handshake FSM state encoding.
package seg_capture_pkg;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0011000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

endpackage

// File: rtl/seg_capture_seven2hex.sv
// Combinational decode of an active-low gfedcba pattern into a hex nibble,
// flagging whether the pattern is a legal digit or the all-off blank.
module seven2hex
    import seg_capture_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] nibble,
    output logic       legal,
    output logic       blank
);

    always_comb begin
        nibble = 4'h0;
        legal  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_n == SEG_HEX[i]) begin
                nibble = 4'(i);
                legal  = 1'b1;
            end
        end
        blank = (seg_n == SEG_BLANK);
    end

endmodule

// File: rtl/seg_capture.sv
// Observes a multiplexed seven-segment display, debounces each digit over
// several sample strobes and offers completed hex snapshots over valid/ready.
module seg_capture
    import seg_capture_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 16,
    parameter int STABLE = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     an_n,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_ok,
    output logic                  bad_pattern,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data
);

    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(STABLE + 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic                strobe;

    int                  low_cnt;
    logic                usable;
    logic [IDX_W-1:0]    an_idx;

    logic [6:0]          pat_q, pat_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                accept;

    logic [3:0]          dec_nibble;
    logic                dec_legal;
    logic                dec_blank;

    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   ok_q, ok_d;
    logic                bad_q, bad_d;

    logic [0:0]          state_q, state_d;
    logic [4*DIGITS-1:0] out_data_q, out_data_d;
    logic [4*DIGITS-1:0] last_q, last_d;
    logic                last_valid_q, last_valid_d;

    seven2hex u_dec (
        .seg_n  (seg_n),
        .nibble (dec_nibble),
        .legal  (dec_legal),
        .blank  (dec_blank)
    );

    always_comb begin
        pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
        strobe = (pre_q == PRE_LAST);
    end

    always_comb begin
        low_cnt = 0;
        an_idx  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_n[i]) begin
                low_cnt = low_cnt + 1;
                an_idx  = IDX_W'(i);
            end
        end
        usable = (low_cnt == 1);
    end

    // Acceptance fires only on the transition into CNT_MAX, so a held digit
    // is reported once per stable run rather than on every strobe.
    always_comb begin
        pat_d  = pat_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        accept = 1'b0;
        if (strobe) begin
            if (!usable) begin
                cnt_d = '0;
            end else if (seg_n == pat_q && an_idx == idx_q) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d  = cnt_q + CNT_ONE;
                    accept = (cnt_d == CNT_MAX);
                end
            end else begin
                pat_d  = seg_n;
                idx_d  = an_idx;
                cnt_d  = CNT_ONE;
                accept = (CNT_ONE == CNT_MAX);
            end
        end
    end

    always_comb begin
        value_d = value_q;
        ok_d    = ok_q;
        bad_d   = 1'b0;
        if (accept) begin
            if (dec_legal) begin
                value_d[{an_idx, 2'b00} +: 4] = dec_nibble;
                ok_d[an_idx]                  = 1'b1;
            end else begin
                ok_d[an_idx] = 1'b0;
                bad_d        = !dec_blank;
            end
        end
    end

    // A snapshot is offered only when it differs from what was last taken,
    // except right after reset when nothing has been delivered yet.
    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        last_d       = last_q;
        last_valid_d = last_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (&ok_q && (!last_valid_q || value_q != last_q)) begin
                    state_d    = ST_OFFER;
                    out_data_d = value_q;
                end
            end
            ST_OFFER: begin
                if (out_ready) begin
                    last_d       = out_data_q;
                    last_valid_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q        <= '0;
            pat_q        <= SEG_BLANK;
            idx_q        <= '0;
            cnt_q        <= '0;
            value_q      <= '0;
            ok_q         <= '0;
            bad_q        <= 1'b0;
            state_q      <= ST_IDLE;
            out_data_q   <= '0;
            last_q       <= '0;
            last_valid_q <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            pat_q        <= pat_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            value_q      <= value_d;
            ok_q         <= ok_d;
            bad_q        <= bad_d;
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            last_q       <= last_d;
            last_valid_q <= last_valid_d;
        end
    end

    assign value       = value_q;
    assign digit_ok    = ok_q;
    assign bad_pattern = bad_q;
    assign out_valid   = (state_q == ST_OFFER);
    assign out_data    = out_data_q;

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits observed.
REQ-002 SHALL have parameter DIV, default 16: clk cycles per sample strobe, minimum 1.
REQ-003 SHALL have parameter STABLE, default 3: identical consecutive samples needed to accept a digit, minimum 1.
REQ-004 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port seg_n, input, 7: observed segments, active-low, bit order {g,f,e,d,c,b,a}.
REQ-007 SHALL have port an_n, input, DIGITS: observed digit strobes, active-low, bit i = digit i (digit 0 = least-significant nibble).
REQ-008 SHALL have port value, output, 4*DIGITS: decoded hex, nibble i from digit i.
REQ-009 SHALL have port digit_ok, output, DIGITS: digit i holds a legally decoded nibble.
REQ-010 SHALL have port bad_pattern, output, 1: one-cycle pulse when an accepted pattern is not in the decode table.
REQ-011 SHALL have port out_valid, output, 1: snapshot offered.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts snapshot.
REQ-013 SHALL have port out_data, output, 4*DIGITS: snapshot payload.

Function
REQ-014 SHALL sample seg_n/an_n once per DIV clk cycles via a free-running prescaler (strobe on count DIV-1, then wrap to 0).
REQ-015 SHALL treat a sample as usable only when exactly one an_n bit is low; zero or multiple low bits SHALL reset the stability counter and change nothing else.
REQ-016 SHALL keep one pattern register and one stability counter; a usable sample matching the stored pattern and digit index increments the counter (saturating at STABLE), otherwise stores the new pattern/index and loads count 1.
REQ-017 SHALL accept a digit on the sample where the counter reaches STABLE, exactly once per stable run.
REQ-018 SHALL decode (active-low, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019 On acceptance of a legal pattern: nibble i updated, digit_ok[i] set, the cycle after the accepting strobe.
REQ-020 On acceptance of blank 1111111: digit_ok[i] cleared, nibble unchanged, no bad_pattern.
REQ-021 On acceptance of any other pattern: digit_ok[i] cleared, nibble unchanged, bad_pattern high for exactly one cycle.
REQ-022 Handshake FSM states IDLE, OFFER: IDLE->OFFER when digit_ok all ones and value differs from last delivered snapshot; out_data loaded from value on that transition.
REQ-023 In OFFER, out_valid SHALL be 1 and out_data SHALL be held stable until out_valid&&out_ready; then last-delivered := out_data, return to IDLE.
REQ-024 The first complete value after reset SHALL always be offered (last-delivered marked invalid).
REQ-025 Value changes during OFFER SHALL NOT alter out_data; a new offer follows only after handshake, in the next cycle at earliest.
REQ-026 out_ready while IDLE SHALL be ignored.

Reset
REQ-027 On reset: prescaler 0, stability counter 0, pattern register 1111111, value 0, digit_ok 0, bad_pattern 0, out_valid 0, out_data 0, FSM IDLE, last-delivered invalid.
REQ-028 Reset asserted mid-offer SHALL drop out_valid the next cycle, no handshake completed.

Structure
REQ-029 A shared package SHALL hold the 16 segment-pattern constants, the blank constant and the FSM state encoding.
REQ-030 Pattern-to-nibble decode SHALL be a combinational sub-module seven2hex (in 7, out nibble 4, out legal 1, out blank 1).

Verification
REQ-031 DIGITS=4, DIV=4, STABLE=3; scan 1,2,3,4 for digits 0..3, 3 strobes each -> value=16'h4321, digit_ok=4'hF, out_valid with out_data=16'h4321.
REQ-032 Hold out_ready=0 for 50 cycles, then change digit 0 to 9 -> out_data stays 16'h4321; after out_ready pulse, new offer 16'h4329.
REQ-033 Present 1111110 on digit 2 for 3 strobes -> single bad_pattern pulse, digit_ok=4'b1011, no offer.
REQ-034 Pattern alternating every strobe, or an_n=4'b0000 / 4'b1100 -> no acceptance, value unchanged.
REQ-035 Repeat identical full scan after delivery -> no second offer; blank digit 1 -> digit_ok[1]=0, no bad_pattern.
REQ-036 Assert reset during OFFER -> out_valid=0 next cycle, all outputs at REQ-027 values.
